// File: rtl/pds_pkg.sv
// ---------------------------------------------------------------
// pds_pkg : shared types for the PDS packet link receive side
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pds_pkg;

  typedef struct packed {
    logic [3:0] source;
    logic [3:0] target;
    logic [7:0] data;
  } pds_word_t;

  localparam logic [3:0] PDS_BCAST = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } pds_rx_state_t;

  function automatic logic tgt_match(input logic [3:0] tgt,
                                     input logic [3:0] port_id,
                                     input logic       bcast_en);
    return (tgt == port_id) || (bcast_en && (tgt == PDS_BCAST));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pds_sync_fifo.sv
// ---------------------------------------------------------------
// pds_sync_fifo : single-clock FIFO, extra pointer bit for full/empty
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pds_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/pds_rx_port.sv
// ---------------------------------------------------------------
// pds_rx_port : filters PDS words for this port, buffers, re-emits as pulses
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pds_rx_port
  import pds_pkg::*;
#(
  parameter logic [3:0] PORT_ID    = 4'h0,
  parameter bit         BCAST_EN   = 1'b1,
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 1,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      data_ip,
  input  logic             valid_up,
  output logic [15:0]      data_op,
  output logic             valid_op,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int               GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pds_rx_state_t state;
  pds_word_t     word_in;
  pds_word_t     head;
  logic [GW-1:0] gap_cnt;
  logic          match;
  logic          gap_done;
  logic          pop;
  logic          write;

  assign word_in  = data_ip;
  assign match    = valid_up && tgt_match(word_in.target, PORT_ID, BCAST_EN);
  assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);
  assign pop      = !fifo_empty && ((state == IDLE) || gap_done);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign write    = match && (!fifo_full || pop);

  pds_sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (write),
    .wdata (word_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (write) begin
      if (pkt_cnt != CNT_MAX) pkt_cnt <= pkt_cnt + CNT_ONE;
    end else if (match) begin
      if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data_op  <= '0;
      valid_op <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SEND;
            data_op  <= head;
            valid_op <= 1'b1;
          end
        end
        SEND: begin
          state    <= GAP;
          valid_op <= 1'b0;
          gap_cnt  <= '0;
        end
        GAP: begin
          if (gap_done) begin
            if (pop) begin
              state    <= SEND;
              data_op  <= head;
              valid_op <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          valid_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
